// File: rtl/dpe_vec_loader.sv
// Serial-to-parallel vector assembler feeding the DPE CSA reduction stage.
// Elements arrive one per cycle on a valid/ready stream and are packed into one
// of two ping-pong banks. Short vectors (closed early by in_last) are zero-padded.
// A completed bank is presented on a valid/ready port while the other bank fills.
//
// Bank state table:
//   state      | meaning
//   BANK_EMPTY | bank is free; it is zeroed and may be (partially) filling
//   BANK_FULL  | bank holds a closed vector awaiting the consumer
module dpe_vec_loader #(
    parameter int INPUT_VEC_LEN = 8,
    parameter int WIDTH         = 16,
    parameter int CNT_W         = $clog2(INPUT_VEC_LEN + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]   out_vec,
    output logic [CNT_W-1:0]                      out_len
);

    localparam int IDX_W = (INPUT_VEC_LEN > 1) ? $clog2(INPUT_VEC_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_VEC_LEN - 1);

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    bank_state_t                           bank_st  [2];
    logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]   bank_vec [2];
    logic [CNT_W-1:0]                      bank_len [2];

    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  idx;

    logic accept;
    logic closing;
    logic rd_release;

    // Handshake qualifiers; ready/valid depend only on bank state so neither
    // port combinationally depends on the other side's valid or ready.
    always_comb begin
        in_ready   = (bank_st[wr_bank] != BANK_FULL);
        out_valid  = (bank_st[rd_bank] == BANK_FULL);
        accept     = in_valid & in_ready;
        closing    = in_last | (idx == LAST_IDX);
        rd_release = out_valid & out_ready;
    end

    // Output mux; a read bank that is still filling must not leak partial data.
    always_comb begin
        out_vec = '0;
        out_len = '0;
        if (out_valid) begin
            out_vec = bank_vec[rd_bank];
            out_len = bank_len[rd_bank];
        end
    end

    // Bank fill / release. A release and a close in the same cycle always touch
    // different banks: the write bank can only equal the read bank while it is
    // not yet FULL, and a release needs the read bank FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= BANK_EMPTY;
                bank_vec[b] <= '0;
                bank_len[b] <= '0;
            end
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            idx     <= '0;
        end else begin
            if (rd_release) begin
                bank_st[rd_bank]  <= BANK_EMPTY;
                bank_vec[rd_bank] <= '0;
                bank_len[rd_bank] <= '0;
                rd_bank           <= ~rd_bank;
            end
            if (accept) begin
                bank_vec[wr_bank][idx] <= in_data;
                if (closing) begin
                    bank_st[wr_bank]  <= BANK_FULL;
                    bank_len[wr_bank] <= CNT_W'(idx) + CNT_W'(1);
                    idx               <= '0;
                    wr_bank           <= ~wr_bank;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dpe_vec_loader.sv
// Directed and randomised checks of the ping-pong vector loader at
// INPUT_VEC_LEN=4, WIDTH=8. Inputs change 1 time unit after the rising edge;
// outputs are observed at that same point, before the next edge.
module tb_dpe_vec_loader;

    localparam int L  = 4;
    localparam int W  = 8;
    localparam int CW = 3;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [L-1:0][W-1:0]   out_vec;
    logic [CW-1:0]         out_len;

    int n_cmp;
    int n_err;

    dpe_vec_loader #(
        .INPUT_VEC_LEN(L),
        .WIDTH        (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .out_len  (out_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_vec !== 32'h0) begin n_err++; $display("FAIL rst_out_vec: got %h want 00000000", out_vec); end
        n_cmp++; if (out_len !== 3'd0) begin n_err++; $display("FAIL rst_out_len: got %0d want 0", out_len); end
        // one full vector pending plus two elements of a partial one
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1); step();
        end
        in_data = 8'h21; step();
        in_data = 8'h22; step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_vec !== 32'h0) begin n_err++; $display("FAIL mid_rst_vec: got %h want 00000000", out_vec); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h31 + i); step();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_vec !== 32'h34333231) begin n_err++; $display("FAIL post_rst_vec: got %h want 34333231", out_vec); end
        n_cmp++; if (out_len !== 3'd4) begin n_err++; $display("FAIL post_rst_len: got %0d want 4", out_len); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_full_vector();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1); in_last = 1'b0;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid[%0d]: got %b want 0", i, out_valid); end
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_vec !== 32'h04030201) begin n_err++; $display("FAIL full_vec: got %h want 04030201", out_vec); end
        n_cmp++; if (out_len !== 3'd4) begin n_err++; $display("FAIL full_len: got %0d want 4", out_len); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_release_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_vec !== 32'h0) begin n_err++; $display("FAIL full_release_vec: got %h want 00000000", out_vec); end
    endtask

    task automatic test_short_vector();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; step();
        in_valid = 1'b0; in_data = 8'hFF; in_last = 1'b1; step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL short_ignored_last: got %b want 0", out_valid); end
        in_valid = 1'b1; in_data = 8'hBB; in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if (out_vec !== 32'h0000BBAA) begin n_err++; $display("FAIL short_vec: got %h want 0000bbaa", out_vec); end
        n_cmp++; if (out_len !== 3'd2) begin n_err++; $display("FAIL short_len: got %0d want 2", out_len); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        // in_last on the final slot must close exactly one vector
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(5 + i); in_last = (i == 3); step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if (out_vec !== 32'h08070605) begin n_err++; $display("FAIL short_next_vec: got %h want 08070605", out_vec); end
        n_cmp++; if (out_len !== 3'd4) begin n_err++; $display("FAIL short_next_len: got %0d want 4", out_len); end
        out_ready = 1'b1; step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL short_no_empty0: got %b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL short_no_empty1: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h40 + i);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_fill_ready[%0d]: got %b want 1", i, in_ready); end
            step();
        end
        in_data = 8'h48;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", i, in_ready); end
            n_cmp++; if (out_vec !== 32'h43424140) begin n_err++; $display("FAIL bp_stall_vec[%0d]: got %h want 43424140", i, out_vec); end
            step();
        end
        out_ready = 1'b1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_release_cycle_ready: got %b want 0", in_ready); end
        step();
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_after_release_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_vec !== 32'h47464544) begin n_err++; $display("FAIL bp_second_vec: got %h want 47464544", out_vec); end
        for (int i = 8; i < 12; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h40 + i); step();
        end
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_refull_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_vec !== 32'h47464544) begin n_err++; $display("FAIL bp_hold_vec: got %h want 47464544", out_vec); end
        out_ready = 1'b1; step();
        n_cmp++; if (out_vec !== 32'h4B4A4948) begin n_err++; $display("FAIL bp_third_vec: got %h want 4b4a4948", out_vec); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_ping_pong();
        logic [L-1:0][W-1:0] ev;
        out_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h80 + k - 1); in_last = 1'b0;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pp_ready[%0d]: got %b want 1", k, in_ready); end
            step();
            n_cmp++; if (out_valid !== (k % 4 == 0)) begin n_err++; $display("FAIL pp_valid[%0d]: got %b want %b", k, out_valid, (k % 4 == 0)); end
            if (k % 4 == 0) begin
                for (int j = 0; j < L; j++) ev[j] = 8'(8'h80 + k - 4 + j);
                n_cmp++; if (out_vec !== ev) begin n_err++; $display("FAIL pp_vec[%0d]: got %h want %h", k, out_vec, ev); end
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pp_drained: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [L-1:0][W-1:0] qv[$];
        int                  ql[$];
        logic [L-1:0][W-1:0] pv;
        int                  pidx;
        int                  sent;
        int                  cycles;
        logic                exp_rdy;
        logic                exp_vld;
        logic                acc;
        logic                rel;
        pv = '0; pidx = 0; sent = 0; cycles = 0;
        while ((sent < 1000 || qv.size() > 0) && cycles < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom_range(0, 255));
            in_last   = ($urandom_range(0, 4) == 0) || (sent == 999);
            out_ready = ($urandom_range(0, 9) < 6);
            exp_rdy = (qv.size() < 2);
            exp_vld = (qv.size() > 0);
            n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready @%0d: got %b want %b", cycles, in_ready, exp_rdy); end
            n_cmp++; if (out_valid !== exp_vld) begin n_err++; $display("FAIL rnd_valid @%0d: got %b want %b", cycles, out_valid, exp_vld); end
            if (exp_vld && out_ready) begin
                n_cmp++; if (out_vec !== qv[0]) begin n_err++; $display("FAIL rnd_vec @%0d: got %h want %h", cycles, out_vec, qv[0]); end
                n_cmp++; if (out_len !== CW'(ql[0])) begin n_err++; $display("FAIL rnd_len @%0d: got %0d want %0d", cycles, out_len, ql[0]); end
            end
            if (!exp_vld) begin
                n_cmp++; if (out_vec !== '0) begin n_err++; $display("FAIL rnd_idle_vec @%0d: got %h want 0", cycles, out_vec); end
            end
            acc = in_valid && exp_rdy;
            rel = out_ready && exp_vld;
            step();
            if (rel) begin
                void'(qv.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                pv[pidx] = in_data;
                pidx++;
                sent++;
                if (in_last || pidx == L) begin
                    qv.push_back(pv);
                    ql.push_back(pidx);
                    pv   = '0;
                    pidx = 0;
                end
            end
            cycles++;
        end
        if (cycles >= 20000) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_timeout: got %0d elements sent, %0d queued want 1000 sent, 0 queued", sent, qv.size());
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #22;
        rst = 1'b0;
        step();
        test_reset();
        test_full_vector();
        test_short_vector();
        test_backpressure();
        test_ping_pong();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
